instr_prefetch: RTL and testbench
=================================

Name: instr_prefetch

Overview:
- Parametrised successor to the processor's byte-at-a-time fetch states: a prefetch unit that streams instruction bytes from the synchronous byte memory into a DEPTH-entry queue.
- Presents up to three head bytes to the decoder so a 1/2/3-byte instruction can be consumed in one cycle.
- Handles jumps by flushing the queue and redirecting fetch.
- Sits between Memory (strobed read, 1-cycle latency) and the decode/execute stage of the next-generation processor.

Parameters:
ADDR_WIDTH, 16, width of PC / memory address; wraps modulo 2^ADDR_WIDTH
DEPTH, 4, queue entries; power of two, >= 3
RESET_PC, 0, fetch start address after reset

Ports:
clk  input  1  clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
mem_addr  output  ADDR_WIDTH  fetch address; valid when mem_strobe=1
mem_strobe  output  1  memory read request; memory registers mem_data on this edge
mem_data  input  8  read data; valid the cycle after a strobed edge
q_count  output  $clog2(DEPTH+1)  number of valid bytes in queue
q_byte0  output  8  queue head (opcode byte)
q_byte1  output  8  head+1; valid when q_count>=2
q_byte2  output  8  head+2; valid when q_count>=3
q_pc  output  ADDR_WIDTH  address of q_byte0
consume  input  2  bytes to pop this cycle (0..3)
jump  input  1  redirect request
jump_addr  input  ADDR_WIDTH  new fetch/queue address when jump=1

Behaviour:
- Reset (async, reset_n=0): q_count=0, q_pc=RESET_PC, fetch_pc=RESET_PC, in_flight=0, mem_strobe=0, q_byte0..2=0, queue storage contents don't-care but q_byte outputs mask to 0 for invalid slots.
- State: fetch_pc, in_flight flag (1 = strobe issued last cycle), queue head/tail pointers (log2(DEPTH) bits, wrap naturally), q_count.
- mem_addr = fetch_pc; mem_strobe = reset_n & ~jump & (q_count + in_flight < DEPTH). The slot reservation ignores the current cycle's consume; no speculative overfill.
- Strobe edge: fetch_pc <= fetch_pc+1 (mod 2^ADDR_WIDTH), in_flight <= 1; otherwise in_flight <= 0.
- Capture: on an edge where in_flight=1 and no jump, mem_data is written at tail, tail++, count++.
- Latency: strobe in cycle n -> data on mem_data in n+1 -> visible in queue (q_count incremented) in n+2. Sustained throughput is 1 byte/cycle while space allows.
- Consume: if consume <= q_count, on the edge head += consume, q_pc += consume (mod), count -= consume. If consume > q_count, the request is ignored entirely (no pop, q_pc unchanged).
- Simultaneous capture and consume in the same edge: count <= count + 1 - consume. Capture into a slot freed by that same consume is legal only because reservation excluded it; a full queue never overflows.
- Jump has priority over consume and capture. On the edge: count <= 0, head=tail=0, q_pc <= jump_addr, fetch_pc <= jump_addr, in_flight <= 0. Any byte returning next cycle from a pre-jump strobe is discarded. No strobe in the jump cycle.
  - Jump in cycle k -> strobe at jump_addr in k+1 -> q_count=1, q_byte0=mem[jump_addr] in k+3.
- Jump while q_count=0 or mid-fill: same as above, no special case.
- Reset mid-operation: all state returns to reset values immediately; fetch restarts at RESET_PC on the first edge with reset_n=1.
- Address wrap: fetch_pc and q_pc wrap from 2^ADDR_WIDTH-1 to 0 with no stall.

Optional Feature:
PREFETCH_UNDERFLOW_CHECK_EN
- Defined: adds output port underflow_err (1 bit, reset 0). It is set sticky on any edge where jump=0 and consume > q_count, and is cleared only by reset. Simulation also prints "prefetch underflow consume=%d count=%d".
- Not defined: port absent, no check logic. Oversized consume is still ignored as specified.

Test Plan:
- Reset release, memory bytes 0x10,0x20,0x30,0x40 at 0..3, consume=0 -> q_count 0,0,1,2,3,4 on successive cycles; strobe stops at count+in_flight=4; q_byte0..2 = 10,20,30; q_pc=0.
- Full queue, then consume=3 one cycle -> q_pc=3, q_byte0=0x40, q_count=1. Refill resumes: strobe at addr 4 next cycle, count reaches 4 again.
- Steady state, consume=1 every cycle -> q_pc increments each cycle, no bubbles after the initial 2-cycle fill, q_byte0 follows memory sequence.
- jump=1, jump_addr=0x1234 while a byte is in flight -> in-flight byte dropped, q_count=0. Strobe addr 0x1234 next cycle; q_count=1 and q_pc=0x1234 two cycles later. Same-cycle consume=2 is ignored.
- ADDR_WIDTH=16, RESET_PC=0xFFFE -> fetched addresses FFFE, FFFF, 0000, 0001. Consume=3 takes q_pc to 0x0001.
- consume=3 with q_count=2 -> no pop, q_pc unchanged. With PREFETCH_UNDERFLOW_CHECK_EN, underflow_err=1 and stays 1 until reset_n pulse.

Source files
------------

// File: rtl/instr_prefetch.sv
// -----------------------------------------------------------------------------
// instr_prefetch
//   Streams instruction bytes from a synchronous byte memory (1-cycle read
//   latency) into a DEPTH-entry queue. The three head bytes go to the decoder
//   so a 1/2/3-byte instruction can be consumed in one cycle. A jump flushes
//   the queue and redirects fetch.
//
// Ports
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   mem_addr/mem_strobe read request to memory (address is fetch_pc)
//   mem_data            read data, valid the cycle after a strobed edge
//   q_count             number of valid bytes in the queue
//   q_byte0..2          head bytes, forced to 0 when the slot is not valid
//   q_pc                address of q_byte0
//   consume             bytes popped this cycle (ignored if > q_count)
//   jump/jump_addr      flush the queue and restart fetch at jump_addr
//   underflow_err       sticky oversized-consume flag (only with the macro)
//
// Build option
//   PREFETCH_UNDERFLOW_CHECK_EN : adds underflow_err and its check logic.
// -----------------------------------------------------------------------------
module instr_prefetch #(
  parameter int unsigned            ADDR_WIDTH = 16,
  parameter int unsigned            DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0
) (
  input  logic                           clk,
  input  logic                           reset_n,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic                           mem_strobe,
  input  logic [7:0]                     mem_data,
  output logic [$clog2(DEPTH+1)-1:0]     q_count,
  output logic [7:0]                     q_byte0,
  output logic [7:0]                     q_byte1,
  output logic [7:0]                     q_byte2,
  output logic [ADDR_WIDTH-1:0]          q_pc,
  input  logic [1:0]                     consume,
  input  logic                           jump,
  input  logic [ADDR_WIDTH-1:0]          jump_addr
`ifdef PREFETCH_UNDERFLOW_CHECK_EN
  ,
  output logic                           underflow_err
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam int unsigned OCC_W = CNT_W + 1;

  // State registers
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] q_pc_q,     q_pc_d;
  logic                  in_flight_q, in_flight_d;
  logic [PTR_W-1:0]      head_q,     head_d;
  logic [PTR_W-1:0]      tail_q,     tail_d;
  logic [CNT_W-1:0]      count_q,    count_d;
  logic [7:0]            store_q [DEPTH];

  // Combinational helpers
  logic [OCC_W-1:0]      occ_c;
  logic                  space_c;
  logic                  strobe_c;
  logic                  capture_c;
  logic                  pop_ok_c;
  logic [1:0]            pop_n_c;
  logic [PTR_W-1:0]      head_p1_c;
  logic [PTR_W-1:0]      head_p2_c;

  // Reservation counts bytes in flight but not this cycle's consume, so a
  // capture always has a free slot even when the queue is being drained.
  assign occ_c     = OCC_W'(count_q) + OCC_W'(in_flight_q);
  assign space_c   = (occ_c < OCC_W'(DEPTH));
  assign strobe_c  = reset_n & ~jump & space_c;
  assign capture_c = in_flight_q & ~jump;
  assign pop_ok_c  = (CNT_W'(consume) <= count_q);
  assign pop_n_c   = pop_ok_c ? consume : 2'd0;

  // Next-state logic; jump overrides capture and consume
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    q_pc_d      = q_pc_q;
    in_flight_d = 1'b0;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;

    if (jump) begin
      fetch_pc_d = jump_addr;
      q_pc_d     = jump_addr;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      if (strobe_c) begin
        fetch_pc_d  = fetch_pc_q + ADDR_WIDTH'(1);
        in_flight_d = 1'b1;
      end
      if (capture_c) begin
        tail_d = tail_q + PTR_W'(1);
      end
      head_d  = head_q + PTR_W'(pop_n_c);
      q_pc_d  = q_pc_q + ADDR_WIDTH'(pop_n_c);
      count_d = count_q + CNT_W'(capture_c) - CNT_W'(pop_n_c);
    end
  end

  // Control state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q  <= RESET_PC;
      q_pc_q      <= RESET_PC;
      in_flight_q <= 1'b0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      q_pc_q      <= q_pc_d;
      in_flight_q <= in_flight_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
    end
  end

  // Queue storage; contents are don't-care out of reset
  always_ff @(posedge clk) begin
    if (capture_c) begin
      store_q[tail_q] <= mem_data;
    end
  end

  // Head window, masked to 0 for slots beyond q_count
  assign head_p1_c = head_q + PTR_W'(1);
  assign head_p2_c = head_q + PTR_W'(2);

  assign q_byte0 = (count_q >= CNT_W'(1)) ? store_q[head_q]    : 8'h00;
  assign q_byte1 = (count_q >= CNT_W'(2)) ? store_q[head_p1_c] : 8'h00;
  assign q_byte2 = (count_q >= CNT_W'(3)) ? store_q[head_p2_c] : 8'h00;

  assign mem_addr   = fetch_pc_q;
  assign mem_strobe = strobe_c;
  assign q_count    = count_q;
  assign q_pc       = q_pc_q;

`ifdef PREFETCH_UNDERFLOW_CHECK_EN
  logic underflow_q;

  // Sticky flag for a consume larger than the queue holds
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      underflow_q <= 1'b0;
    end else if (!jump && !pop_ok_c) begin
      underflow_q <= 1'b1;
    end
  end

  assign underflow_err = underflow_q;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset_n && !jump && !pop_ok_c) begin
      $display("prefetch underflow consume=%d count=%d", consume, count_q);
    end
  end
`endif
`endif

endmodule

// File: tb/tb_instr_prefetch.sv
// -----------------------------------------------------------------------------
// tb_instr_prefetch
//   Table-driven bench for instr_prefetch. Each vector is one clock cycle:
//   inputs driven at the falling edge and the outputs expected in that cycle.
//   Two instances: u_main (RESET_PC=0) and u_wrap (RESET_PC=0xFFFE).
// -----------------------------------------------------------------------------
module tb_instr_prefetch;

  localparam int unsigned AW = 16;
  localparam int unsigned DP = 4;
  localparam int unsigned CW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          sel;      // 0 = u_main, 1 = u_wrap
    logic [1:0]    consume;
    logic          jump;
    logic [AW-1:0] jaddr;
    logic [CW-1:0] cnt;
    logic [AW-1:0] pc;
    logic [7:0]    b0;
    logic [7:0]    b1;
    logic [7:0]    b2;
    logic          strobe;
    logic [AW-1:0] addr;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  int n_vec  = 0;
  int n_miss = 0;

  // ---------------- main instance ----------------
  logic          rst_n_a = 1'b0;
  logic [1:0]    consume_a = 2'd0;
  logic          jump_a = 1'b0;
  logic [AW-1:0] jaddr_a = '0;
  logic [7:0]    mem_data_a = 8'h00;
  logic [AW-1:0] mem_addr_a;
  logic          strobe_a;
  logic [CW-1:0] cnt_a;
  logic [7:0]    b0_a, b1_a, b2_a;
  logic [AW-1:0] pc_a;
`ifdef PREFETCH_UNDERFLOW_CHECK_EN
  logic          uf_a;
`endif

  instr_prefetch #(.ADDR_WIDTH(AW), .DEPTH(DP), .RESET_PC(16'h0000)) u_main (
    .clk(clk), .reset_n(rst_n_a),
    .mem_addr(mem_addr_a), .mem_strobe(strobe_a), .mem_data(mem_data_a),
    .q_count(cnt_a), .q_byte0(b0_a), .q_byte1(b1_a), .q_byte2(b2_a),
    .q_pc(pc_a), .consume(consume_a), .jump(jump_a), .jump_addr(jaddr_a)
`ifdef PREFETCH_UNDERFLOW_CHECK_EN
    , .underflow_err(uf_a)
`endif
  );

  // ---------------- wrap instance ----------------
  logic          rst_n_b = 1'b0;
  logic [1:0]    consume_b = 2'd0;
  logic          jump_b = 1'b0;
  logic [AW-1:0] jaddr_b = '0;
  logic [7:0]    mem_data_b = 8'h00;
  logic [AW-1:0] mem_addr_b;
  logic          strobe_b;
  logic [CW-1:0] cnt_b;
  logic [7:0]    b0_b, b1_b, b2_b;
  logic [AW-1:0] pc_b;
`ifdef PREFETCH_UNDERFLOW_CHECK_EN
  logic          uf_b;
`endif

  instr_prefetch #(.ADDR_WIDTH(AW), .DEPTH(DP), .RESET_PC(16'hFFFE)) u_wrap (
    .clk(clk), .reset_n(rst_n_b),
    .mem_addr(mem_addr_b), .mem_strobe(strobe_b), .mem_data(mem_data_b),
    .q_count(cnt_b), .q_byte0(b0_b), .q_byte1(b1_b), .q_byte2(b2_b),
    .q_pc(pc_b), .consume(consume_b), .jump(jump_b), .jump_addr(jaddr_b)
`ifdef PREFETCH_UNDERFLOW_CHECK_EN
    , .underflow_err(uf_b)
`endif
  );

  // Memory image: 10,20,30,40 at 0..3, a hash of the address elsewhere
  function automatic logic [7:0] m(input int unsigned x);
    logic [AW-1:0] a;
    a = AW'(x);
    if (a < 16'd4) return {4'(a[3:0] + 4'd1), 4'h0};
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  // Synchronous byte memories with one-cycle read latency
  always @(posedge clk) if (strobe_a) mem_data_a <= m(int'(mem_addr_a));
  always @(posedge clk) if (strobe_b) mem_data_b <= m(int'(mem_addr_b));

  function automatic vec_t mk(input logic sel, input int unsigned cons, input logic jmp,
                              input int unsigned ja, input int unsigned cnt,
                              input int unsigned pc, input logic [7:0] b0,
                              input logic [7:0] b1, input logic [7:0] b2,
                              input logic stb, input int unsigned addr);
    vec_t v;
    v.sel = sel; v.consume = 2'(cons); v.jump = jmp; v.jaddr = AW'(ja);
    v.cnt = CW'(cnt); v.pc = AW'(pc); v.b0 = b0; v.b1 = b1; v.b2 = b2;
    v.strobe = stb; v.addr = AW'(addr);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one vector at the falling edge, compare 1ns later, wait next fall
  task automatic run_vec(input vec_t v);
    vec_t e;
    if (v.sel) begin
      consume_b = v.consume; jump_b = v.jump; jaddr_b = v.jaddr;
    end else begin
      consume_a = v.consume; jump_a = v.jump; jaddr_a = v.jaddr;
    end
    sb.push_back(v);
    #1;
    e = sb.pop_front();
    n_vec++;
    if (e.sel) begin
      chk("wrap.q_count", 32'(cnt_b), 32'(e.cnt));
      chk("wrap.q_pc",    32'(pc_b),  32'(e.pc));
      chk("wrap.q_byte0", 32'(b0_b),  32'(e.b0));
      chk("wrap.q_byte1", 32'(b1_b),  32'(e.b1));
      chk("wrap.q_byte2", 32'(b2_b),  32'(e.b2));
      chk("wrap.strobe",  32'(strobe_b), 32'(e.strobe));
      if (e.strobe) chk("wrap.mem_addr", 32'(mem_addr_b), 32'(e.addr));
    end else begin
      chk("main.q_count", 32'(cnt_a), 32'(e.cnt));
      chk("main.q_pc",    32'(pc_a),  32'(e.pc));
      chk("main.q_byte0", 32'(b0_a),  32'(e.b0));
      chk("main.q_byte1", 32'(b1_a),  32'(e.b1));
      chk("main.q_byte2", 32'(b2_a),  32'(e.b2));
      chk("main.strobe",  32'(strobe_a), 32'(e.strobe));
      if (e.strobe) chk("main.mem_addr", 32'(mem_addr_a), 32'(e.addr));
    end
    @(negedge clk);
  endtask

  initial begin
    // ---- main table: fill, drain by 3, refill, steady, jump, underflow ----
    tbl.push_back(mk(0,0,0,0, 0,0, 8'h00,8'h00,8'h00, 1,0));           // c0
    tbl.push_back(mk(0,0,0,0, 0,0, 8'h00,8'h00,8'h00, 1,1));           // c1
    tbl.push_back(mk(0,0,0,0, 1,0, 8'h10,8'h00,8'h00, 1,2));           // c2
    tbl.push_back(mk(0,0,0,0, 2,0, 8'h10,8'h20,8'h00, 1,3));           // c3
    tbl.push_back(mk(0,0,0,0, 3,0, 8'h10,8'h20,8'h30, 0,4));           // c4
    tbl.push_back(mk(0,0,0,0, 4,0, 8'h10,8'h20,8'h30, 0,4));           // c5
    tbl.push_back(mk(0,3,0,0, 4,0, 8'h10,8'h20,8'h30, 0,4));           // c6 consume 3
    tbl.push_back(mk(0,0,0,0, 1,3, 8'h40,8'h00,8'h00, 1,4));           // c7
    tbl.push_back(mk(0,0,0,0, 1,3, 8'h40,8'h00,8'h00, 1,5));           // c8
    tbl.push_back(mk(0,0,0,0, 2,3, 8'h40,m(4),8'h00, 1,6));            // c9
    tbl.push_back(mk(0,0,0,0, 3,3, 8'h40,m(4),m(5), 0,7));             // c10
    tbl.push_back(mk(0,0,0,0, 4,3, 8'h40,m(4),m(5), 0,7));             // c11
    tbl.push_back(mk(0,1,0,0, 4,3, 8'h40,m(4),m(5), 0,7));             // c12
    tbl.push_back(mk(0,1,0,0, 3,4, m(4),m(5),m(6), 1,7));              // c13
    for (int k = 5; k <= 10; k++)                                      // c14..c19
      tbl.push_back(mk(0,1,0,0, 2,k, m(k),m(k+1),8'h00, 1,k+3));
    tbl.push_back(mk(0,2,1,16'h1234, 2,11, m(11),m(12),8'h00, 0,14));  // c20 jump
    tbl.push_back(mk(0,0,0,0, 0,16'h1234, 8'h00,8'h00,8'h00, 1,16'h1234));
    tbl.push_back(mk(0,0,0,0, 0,16'h1234, 8'h00,8'h00,8'h00, 1,16'h1235));
    tbl.push_back(mk(0,0,0,0, 1,16'h1234, m(16'h1234),8'h00,8'h00, 1,16'h1236));
    tbl.push_back(mk(0,3,0,0, 2,16'h1234, m(16'h1234),m(16'h1235),8'h00, 1,16'h1237)); // underflow
    tbl.push_back(mk(0,0,0,0, 3,16'h1234, m(16'h1234),m(16'h1235),m(16'h1236), 0,16'h1237));
    tbl.push_back(mk(0,0,0,0, 4,16'h1234, m(16'h1234),m(16'h1235),m(16'h1236), 0,16'h1237));
    // ---- wrap table: RESET_PC = 0xFFFE ----
    tbl.push_back(mk(1,0,0,0, 0,16'hFFFE, 8'h00,8'h00,8'h00, 1,16'hFFFE));
    tbl.push_back(mk(1,0,0,0, 0,16'hFFFE, 8'h00,8'h00,8'h00, 1,16'hFFFF));
    tbl.push_back(mk(1,0,0,0, 1,16'hFFFE, m(16'hFFFE),8'h00,8'h00, 1,16'h0000));
    tbl.push_back(mk(1,0,0,0, 2,16'hFFFE, m(16'hFFFE),m(16'hFFFF),8'h00, 1,16'h0001));
    tbl.push_back(mk(1,0,0,0, 3,16'hFFFE, m(16'hFFFE),m(16'hFFFF),8'h10, 0,16'h0002));
    tbl.push_back(mk(1,0,0,0, 4,16'hFFFE, m(16'hFFFE),m(16'hFFFF),8'h10, 0,16'h0002));
    tbl.push_back(mk(1,3,0,0, 4,16'hFFFE, m(16'hFFFE),m(16'hFFFF),8'h10, 0,16'h0002));
    tbl.push_back(mk(1,0,0,0, 1,16'h0001, 8'h20,8'h00,8'h00, 1,16'h0002));

    // ---- reset state ----
    repeat (2) @(negedge clk);
    n_vec++;
    chk("rst.q_count", 32'(cnt_a), 32'd0);
    chk("rst.q_pc",    32'(pc_a), 32'd0);
    chk("rst.strobe",  32'(strobe_a), 32'd0);
    chk("rst.q_byte0", 32'(b0_a), 32'd0);
    chk("rst.mem_addr", 32'(mem_addr_a), 32'd0);
`ifdef PREFETCH_UNDERFLOW_CHECK_EN
    chk("rst.underflow_err", 32'(uf_a), 32'd0);
`endif

    // ---- main sequence, released at this falling edge ----
    rst_n_a = 1'b1;
    foreach (tbl[i]) if (!tbl[i].sel) run_vec(tbl[i]);

`ifdef PREFETCH_UNDERFLOW_CHECK_EN
    n_vec++;
    chk("underflow_err.sticky", 32'(uf_a), 32'd1);
`endif

    // ---- asynchronous reset mid-operation (queue full) ----
    #2 rst_n_a = 1'b0;
    #1;
    n_vec++;
    chk("midrst.q_count",  32'(cnt_a), 32'd0);
    chk("midrst.q_pc",     32'(pc_a), 32'd0);
    chk("midrst.mem_addr", 32'(mem_addr_a), 32'd0);
    chk("midrst.strobe",   32'(strobe_a), 32'd0);
    chk("midrst.q_byte0",  32'(b0_a), 32'd0);
`ifdef PREFETCH_UNDERFLOW_CHECK_EN
    chk("midrst.underflow_err", 32'(uf_a), 32'd0);
`endif
    @(negedge clk);
    rst_n_a = 1'b1;
    #1;
    n_vec++;
    chk("restart.strobe",   32'(strobe_a), 32'd1);
    chk("restart.mem_addr", 32'(mem_addr_a), 32'd0);
    @(negedge clk);
    rst_n_a = 1'b0;

    // ---- wrap sequence on the second instance ----
    rst_n_b = 1'b1;
    foreach (tbl[i]) if (tbl[i].sel) run_vec(tbl[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

endmodule
